// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 power-up / command sequencer.
package oled_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_FETCH,
      ST_DELAY,
      ST_REQ,
      ST_CLR,
      ST_READY
   } state_t;

   localparam int unsigned STEP_W   = 5;
   localparam int unsigned CNT_W    = 27;
   localparam int unsigned INIT_LEN = 21;

   // For SET_* steps, arg[0] is the level driven onto the (active-low) pin.
   localparam logic [2:0] OP_SET_VDD  = 3'd0;
   localparam logic [2:0] OP_SET_RES  = 3'd1;
   localparam logic [2:0] OP_SET_VBAT = 3'd2;
   localparam logic [2:0] OP_WAIT_MS  = 3'd3;
   localparam logic [2:0] OP_SEND_CMD = 3'd4;
   localparam logic [2:0] OP_END      = 3'd5;

   localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
   localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
   localparam logic [7:0] CMD_CP_ENABLE     = 8'h14;
   localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
   localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
   localparam logic [7:0] CMD_CONTRAST      = 8'h81;
   localparam logic [7:0] CMD_CONTRAST_VAL  = 8'h0F;
   localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
   localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
   localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
   localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h20;
   localparam logic [7:0] CMD_DISP_ON       = 8'hAF;

   function automatic logic [10:0] mk_step(input logic [2:0] op, input logic [7:0] arg);
      return {op, arg};
   endfunction

endpackage

// File: rtl/oled_init_seq_if.sv
// Byte request/done handshake between the sequencer and the SPI byte controller.
interface oled_init_seq_if;
   logic [7:0] spi_din;
   logic       spi_din_valid;
   logic       spi_sdone;

   modport master (output spi_din, output spi_din_valid, input spi_sdone);
   modport slave  (input spi_din, input spi_din_valid, output spi_sdone);
endinterface

// File: rtl/oled_init_rom.sv
// Fixed SSD1306 init step list: step index -> {opcode, arg}.
module oled_init_rom
   import oled_pkg::*;
(
   input  logic [STEP_W-1:0] idx,
   output logic [10:0]       step_word
);

   always_comb begin
      step_word = mk_step(OP_END, 8'h00);
      unique case (idx)
         5'd0:  step_word = mk_step(OP_SET_VDD,  8'h00);
         5'd1:  step_word = mk_step(OP_WAIT_MS,  8'd1);
         5'd2:  step_word = mk_step(OP_SEND_CMD, CMD_DISP_OFF);
         5'd3:  step_word = mk_step(OP_SET_RES,  8'h00);
         5'd4:  step_word = mk_step(OP_WAIT_MS,  8'd1);
         5'd5:  step_word = mk_step(OP_SET_RES,  8'h01);
         5'd6:  step_word = mk_step(OP_WAIT_MS,  8'd1);
         5'd7:  step_word = mk_step(OP_SEND_CMD, CMD_CHARGE_PUMP);
         5'd8:  step_word = mk_step(OP_SEND_CMD, CMD_CP_ENABLE);
         5'd9:  step_word = mk_step(OP_SEND_CMD, CMD_PRECHARGE);
         5'd10: step_word = mk_step(OP_SEND_CMD, CMD_PRECHARGE_VAL);
         5'd11: step_word = mk_step(OP_SET_VBAT, 8'h00);
         5'd12: step_word = mk_step(OP_WAIT_MS,  8'd100);
         5'd13: step_word = mk_step(OP_SEND_CMD, CMD_CONTRAST);
         5'd14: step_word = mk_step(OP_SEND_CMD, CMD_CONTRAST_VAL);
         5'd15: step_word = mk_step(OP_SEND_CMD, CMD_SEG_REMAP);
         5'd16: step_word = mk_step(OP_SEND_CMD, CMD_COM_SCAN_DEC);
         5'd17: step_word = mk_step(OP_SEND_CMD, CMD_COM_PINS);
         5'd18: step_word = mk_step(OP_SEND_CMD, CMD_COM_PINS_VAL);
         5'd19: step_word = mk_step(OP_SEND_CMD, CMD_DISP_ON);
         default: step_word = mk_step(OP_END, 8'h00);
      endcase
   end

endmodule

// File: rtl/oled_init_seq.sv
// SSD1306 power-up sequencer: rails, reset pulse, init command list, then
// forwards user command/data bytes to the SPI byte controller one at a time.
module oled_init_seq
   import oled_pkg::*;
#(
   parameter int unsigned MS_TICKS = 100000
)(
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   start,
   input  logic [7:0]             user_byte,
   input  logic                   user_dc,
   input  logic                   user_valid,
   output logic                   user_ready,
   oled_init_seq_if.master        spi,
   output logic                   oled_dc,
   output logic                   oled_res_n,
   output logic                   oled_vdd_n,
   output logic                   oled_vbat_n,
   output logic                   busy,
   output logic                   init_done
);

   localparam logic [CNT_W-1:0] MS_CNT = CNT_W'(MS_TICKS);

   state_t             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         din_q, din_d;
   logic               dc_q, dc_d;
   logic               res_q, res_d;
   logic               vdd_q, vdd_d;
   logic               vbat_q, vbat_d;
   logic               ret_q, ret_d;
   logic               sdone_m, sdone_s;

   logic [10:0]        rom_word;
   logic [2:0]         rom_op;
   logic [7:0]         rom_arg;

   oled_init_rom u_rom (
      .idx       (step_q),
      .step_word (rom_word)
   );

   assign rom_op  = rom_word[10:8];
   assign rom_arg = rom_word[7:0];

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         sdone_m <= 1'b0;
         sdone_s <= 1'b0;
      end else begin
         sdone_m <= spi.spi_sdone;
         sdone_s <= sdone_m;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= ST_OFF;
         step_q  <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         dc_q    <= 1'b0;
         res_q   <= 1'b1;
         vdd_q   <= 1'b1;
         vbat_q  <= 1'b1;
         ret_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         dc_q    <= dc_d;
         res_q   <= res_d;
         vdd_q   <= vdd_d;
         vbat_q  <= vbat_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      dc_d    = dc_q;
      res_d   = res_q;
      vdd_d   = vdd_q;
      vbat_d  = vbat_q;
      ret_d   = ret_q;

      unique case (state_q)
         ST_OFF: begin
            if (start) begin
               state_d = ST_FETCH;
               step_d  = '0;
            end
         end

         ST_FETCH: begin
            unique case (rom_op)
               OP_SET_VDD: begin
                  vdd_d  = rom_arg[0];
                  step_d = step_q + 5'd1;
               end
               OP_SET_RES: begin
                  res_d  = rom_arg[0];
                  step_d = step_q + 5'd1;
               end
               OP_SET_VBAT: begin
                  vbat_d = rom_arg[0];
                  step_d = step_q + 5'd1;
               end
               // DELAY spends cnt+1 cycles, so preload one less than the tick total.
               OP_WAIT_MS: begin
                  cnt_d   = ({{(CNT_W-8){1'b0}}, rom_arg} * MS_CNT) - 27'd1;
                  state_d = ST_DELAY;
               end
               OP_SEND_CMD: begin
                  din_d   = rom_arg;
                  dc_d    = 1'b0;
                  ret_d   = 1'b0;
                  state_d = ST_REQ;
               end
               default: state_d = ST_READY;
            endcase
         end

         ST_DELAY: begin
            if (cnt_q == '0) begin
               step_d  = step_q + 5'd1;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q - 27'd1;
            end
         end

         ST_REQ: begin
            if (sdone_s) state_d = ST_CLR;
         end

         // A done flag that is still high from the previous byte must fall first.
         ST_CLR: begin
            if (!sdone_s) begin
               if (ret_q) begin
                  state_d = ST_READY;
               end else begin
                  step_d  = step_q + 5'd1;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_READY: begin
            if (user_valid) begin
               din_d   = user_byte;
               dc_d    = user_dc;
               ret_d   = 1'b1;
               state_d = ST_REQ;
            end
         end

         default: state_d = ST_OFF;
      endcase
   end

   assign spi.spi_din       = din_q;
   assign spi.spi_din_valid = (state_q == ST_REQ);
   assign oled_dc           = dc_q;
   assign oled_res_n        = res_q;
   assign oled_vdd_n        = vdd_q;
   assign oled_vbat_n       = vbat_q;
   assign user_ready        = (state_q == ST_READY);
   assign init_done         = (state_q == ST_READY) ||
                              (((state_q == ST_REQ) || (state_q == ST_CLR)) && ret_q);
   assign busy              = (state_q == ST_FETCH) || (state_q == ST_DELAY) ||
                              (((state_q == ST_REQ) || (state_q == ST_CLR)) && !ret_q);

endmodule

// File: tb/tb_oled_init_seq.sv
// Directed bench for oled_init_seq with a behavioural SPI byte controller model.
module tb_oled_init_seq;

   localparam int unsigned MS = 10;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] user_byte = 8'h00;
   logic       user_dc = 1'b0;
   logic       user_valid = 1'b0;
   logic       user_ready, oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n, busy, init_done;

   oled_init_seq_if bus ();

   oled_init_seq #(.MS_TICKS(MS)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .user_byte   (user_byte),
      .user_dc     (user_dc),
      .user_valid  (user_valid),
      .user_ready  (user_ready),
      .spi         (bus.master),
      .oled_dc     (oled_dc),
      .oled_res_n  (oled_res_n),
      .oled_vdd_n  (oled_vdd_n),
      .oled_vbat_n (oled_vbat_n),
      .busy        (busy),
      .init_done   (init_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SPI model: done rises 20 cycles after a request, stays up hold_cyc cycles after it drops.
   int hold_cyc = 0;
   int m_st = 0;
   int m_cnt = 0;
   int early_req = 0;

   always @(posedge clk) begin
      if (!arst_n) begin
         m_st          <= 0;
         m_cnt         <= 0;
         bus.spi_sdone <= 1'b0;
      end else begin
         case (m_st)
            0: if (bus.spi_din_valid) begin m_cnt <= 1; m_st <= 1; end
            1: if (m_cnt >= 19) begin bus.spi_sdone <= 1'b1; m_st <= 2; end
               else m_cnt <= m_cnt + 1;
            2: if (!bus.spi_din_valid) begin m_cnt <= 0; m_st <= 3; end
            3: begin
               if (bus.spi_din_valid) early_req <= early_req + 1;
               if (m_cnt >= hold_cyc) begin bus.spi_sdone <= 1'b0; m_st <= 0; end
               else m_cnt <= m_cnt + 1;
            end
            default: m_st <= 0;
         endcase
      end
   end

   int         cyc = 0;
   logic       prev_valid = 1'b0, prev_res = 1'b1, prev_vbat = 1'b1, prev_vdd = 1'b1;
   logic [8:0] cur = '0;
   logic [8:0] bytes[$];
   int         byte_cyc[$];
   int         res_fall = -1, res_rise = -1, vbat_fall = -1, vdd_fall = -1;
   int         ready_in_xfer = 0, din_unstable = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.spi_din_valid && !prev_valid) begin
         bytes.push_back({oled_dc, bus.spi_din});
         byte_cyc.push_back(cyc);
         cur <= {oled_dc, bus.spi_din};
      end else if (bus.spi_din_valid && ({oled_dc, bus.spi_din} !== cur)) begin
         din_unstable <= din_unstable + 1;
      end
      if (bus.spi_din_valid && user_ready) ready_in_xfer <= ready_in_xfer + 1;
      if (!oled_res_n && prev_res)   res_fall  <= cyc;
      if (oled_res_n && !prev_res)   res_rise  <= cyc;
      if (!oled_vbat_n && prev_vbat) vbat_fall <= cyc;
      if (!oled_vdd_n && prev_vdd)   vdd_fall  <= cyc;
      prev_valid <= bus.spi_din_valid;
      prev_res   <= oled_res_n;
      prev_vbat  <= oled_vbat_n;
      prev_vdd   <= oled_vdd_n;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!user_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(user_ready), 32'd1);
   endtask

   // Leaves user_valid high so consecutive calls go back-to-back.
   task automatic send_user(input logic [7:0] b, input logic dc);
      int n;
      user_byte  = b;
      user_dc    = dc;
      user_valid = 1'b1;
      n = 0;
      while (!user_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("hs_ready", 32'(user_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_init_bytes(input string tag, input int base);
      logic [7:0] exp_b [12];
      exp_b = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
      check({tag, "_count"}, 32'(bytes.size() - base), 32'd12);
      if (bytes.size() >= base + 12) begin
         for (int i = 0; i < 12; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(bytes[base + i]), {23'd0, 1'b0, exp_b[i]});
      end
   endtask

   int base;
   int r0;
   int e0;

   initial begin
      // reset values
      arst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_din",       32'(bus.spi_din),       32'h00);
      check("rst_valid",     32'(bus.spi_din_valid), 32'd0);
      check("rst_dc",        32'(oled_dc),           32'd0);
      check("rst_res_n",     32'(oled_res_n),        32'd1);
      check("rst_vdd_n",     32'(oled_vdd_n),        32'd1);
      check("rst_vbat_n",    32'(oled_vbat_n),       32'd1);
      check("rst_busy",      32'(busy),              32'd0);
      check("rst_init_done", 32'(init_done),         32'd0);
      check("rst_ready",     32'(user_ready),        32'd0);
      arst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_vdd_n", 32'(oled_vdd_n), 32'd1);
      check("idle_busy",  32'(busy),       32'd0);
      check("idle_bytes", 32'(bytes.size()), 32'd0);

      // power-up with an ignored start in the middle
      base = bytes.size();
      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      repeat (100) @(negedge clk);
      pulse_start();
      wait_ready("init", 5000);
      check_init_bytes("init", base);
      if (bytes.size() >= base + 12) begin
         check("vdd_before_ae",  32'(vdd_fall < byte_cyc[base]), 32'd1);
         check("vbat_after_f1",  32'(vbat_fall > byte_cyc[base + 4]), 32'd1);
         check("vbat_to_81_gap", 32'(byte_cyc[base + 5] - vbat_fall), 32'd1002);
      end
      check("res_low_width", 32'(res_rise - res_fall), 32'd12);
      check("init_done",     32'(init_done), 32'd1);
      check("init_busy",     32'(busy),      32'd0);

      // back-to-back user bytes
      base = bytes.size();
      r0 = ready_in_xfer;
      send_user(8'h40, 1'b1);
      send_user(8'hA5, 1'b0);
      user_valid = 1'b0;
      wait_ready("user", 500);
      repeat (30) @(negedge clk);
      check("user_count", 32'(bytes.size() - base), 32'd2);
      if (bytes.size() >= base + 2) begin
         check("user_b0", 32'(bytes[base]),     32'h140);
         check("user_b1", 32'(bytes[base + 1]), 32'h0A5);
      end
      check("ready_low_in_xfer", 32'(ready_in_xfer - r0), 32'd0);

      // done flag held high long after each byte
      hold_cyc = 50;
      base = bytes.size();
      e0 = early_req;
      @(negedge clk);
      send_user(8'h3C, 1'b1);
      send_user(8'hC3, 1'b0);
      user_valid = 1'b0;
      wait_ready("hold", 500);
      check("hold_sdone_low", 32'(bus.spi_sdone), 32'd0);
      repeat (60) @(negedge clk);
      check("hold_count", 32'(bytes.size() - base), 32'd2);
      if (bytes.size() >= base + 2) begin
         check("hold_b0", 32'(bytes[base]),     32'h13C);
         check("hold_b1", 32'(bytes[base + 1]), 32'h0C3);
      end
      check("hold_early_req", 32'(early_req - e0), 32'd0);
      hold_cyc = 0;

      // reset during the 100 ms wait
      @(negedge clk) arst_n = 1'b0;
      @(negedge clk) arst_n = 1'b1;
      pulse_start();
      begin
         int n;
         n = 0;
         while (oled_vbat_n && n < 1000) begin @(negedge clk); n++; end
      end
      check("pre_rst_vbat_on", 32'(oled_vbat_n), 32'd0);
      repeat (200) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      arst_n = 1'b0;
      @(posedge clk);
      #1;
      check("wrst_vdd_n",  32'(oled_vdd_n),        32'd1);
      check("wrst_vbat_n", 32'(oled_vbat_n),       32'd1);
      check("wrst_valid",  32'(bus.spi_din_valid), 32'd0);
      check("wrst_busy",   32'(busy),              32'd0);
      @(negedge clk) arst_n = 1'b1;
      base = bytes.size();
      pulse_start();
      wait_ready("replay1", 5000);
      check_init_bytes("replay1", base);

      // reset during a byte transfer
      @(negedge clk);
      send_user(8'h55, 1'b1);
      user_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_valid_high", 32'(bus.spi_din_valid), 32'd1);
      arst_n = 1'b0;
      @(posedge clk);
      #1;
      check("brst_valid",  32'(bus.spi_din_valid), 32'd0);
      check("brst_vdd_n",  32'(oled_vdd_n),        32'd1);
      check("brst_vbat_n", 32'(oled_vbat_n),       32'd1);
      check("brst_din",    32'(bus.spi_din),       32'h00);
      @(negedge clk) arst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("brst_stay_off", 32'(oled_vdd_n), 32'd1);
      base = bytes.size();
      pulse_start();
      wait_ready("replay2", 5000);
      check_init_bytes("replay2", base);

      check("din_stable",      32'(din_unstable), 32'd0);
      check("no_early_req",    32'(early_req),    32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
